// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: datapath width, reset vector and the
// {pc, instr} record carried from instruction fetch into decode.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO that buffers fetched instructions ahead of decode.
// Ports:
//   clk, resetN       - clock, asynchronous active-low reset
//   push, pushData    - write one entry (ignored when full)
//   pop               - remove the head entry (ignored when empty)
//   clear             - synchronous flush; wins over push and pop
//   head              - oldest entry, zero while the FIFO is empty
//   count             - number of stored entries (0..DEPTH)
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify push/pop against the current fill level.
  always_comb begin
    do_push = push & (count < FULL);
    do_pop  = pop & (count != '0);
  end

  // Storage, pointers and fill count; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= pushData;
        wr_ptr      <= wr_ptr + AW'(1'b1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1'b1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1'b1);
        2'b01:   count <= count - CW'(1'b1);
        default: count <= count;
      endcase
    end
  end

  // Head is forced to zero when empty so stale words never reach decode.
  always_comb begin
    if (count != '0) begin
      head = mem[rd_ptr];
    end else begin
      head = '0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the PC, issues reads to a 1-cycle-latency
// synchronous instruction memory, buffers the returned words and presents
// {pc, instr} to decode over a valid/ready handshake. A redirect flushes
// the wrong-path stream and restarts fetch at the jump target.
// Ports:
//   clk, resetN                   - clock, asynchronous active-low reset
//   jumpEn, jumpTarget            - redirect request and target address
//   imemReq, imemAddr, imemData   - instruction memory read interface
//   instrValid, instrReady        - handshake towards decode
//   instrOut, pcOut               - instruction word and its address
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            jumpEn,
  input  logic [XLEN-1:0] jumpTarget,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic [XLEN-1:0] imemData,
  output logic            instrValid,
  input  logic            instrReady,
  output logic [XLEN-1:0] instrOut,
  output logic [XLEN-1:0] pcOut
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            pop;
  logic            issue;
  logic            push;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // Issue only when the buffer can still absorb this request's response,
  // counting the response already in flight and the entry leaving this cycle.
  // resetN gates the strobe so nothing is requested while held in reset.
  always_comb begin
    pop       = instrValid & instrReady;
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    if (resetN && !jumpEn && (occupancy < LIMIT)) begin
      issue = 1'b1;
    end else begin
      issue = 1'b0;
    end
    push           = inflight & ~jumpEn;
    push_data.pc    = inflight_pc;
    push_data.instr = imemData;
  end

  assign imemReq    = issue;
  assign imemAddr   = pc;
  assign instrValid = (count != '0);
  assign instrOut   = head.instr;
  assign pcOut      = head.pc;

  // PC and in-flight tracking; a redirect drops any outstanding response.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (jumpEn) begin
      pc       <= {jumpTarget[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + XLEN'(3'd4);
        inflight_pc <= pc;
      end else begin
        pc          <= pc;
        inflight_pc <= inflight_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk      (clk),
    .resetN   (resetN),
    .push     (push),
    .pushData (push_data),
    .pop      (pop),
    .clear    (jumpEn),
    .head     (head),
    .count    (count)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that produces the program stream consumed by decode. It sits directly downstream of the jump/flush decision.
- Generates PC and requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a small FIFO and hands {pc, instr} to decode over a valid/ready handshake.
- On jumpEn it redirects to jumpTarget and discards everything fetched on the wrong path.

Parameters:
XLEN, 32, width of PC and instruction word
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, fetch buffer entries; power of two, >=2 (2 sustains 1 instr/cycle)

Ports:
clk  input  1  single clock, rising edge
resetN  input  1  reset, asynchronous, active-low
jumpEn  input  1  redirect request, sampled synchronously
jumpTarget  input  XLEN  redirect PC, valid when jumpEn=1; low 2 bits ignored (forced 0)
imemReq  output  1  instruction memory read strobe
imemAddr  output  XLEN  read address, valid when imemReq=1
imemData  input  XLEN  read data, valid the cycle after imemReq
instrValid  output  1  instrOut/pcOut hold a valid instruction
instrReady  input  1  decode accepts when instrValid & instrReady
instrOut  output  XLEN  instruction word
pcOut  output  XLEN  address of instrOut

Behaviour:
- Reset (resetN=0, async):
  - pc=RESET_PC.
  - imemReq=0, imemAddr=RESET_PC.
  - FIFO empty; instrValid=0; instrOut=0; pcOut=0.
  - inflight=0.
- Registered state:
  - pc (next fetch address)
  - inflight (1 bit: request issued last cycle)
  - inflightPc
  - FIFO count/rd/wr pointers
- Definitions:
  - pop = instrValid & instrReady.
  - canIssue = (count + inflight - pop) < DEPTH.
- Normal cycle (jumpEn=0):
  - imemReq=canIssue; imemAddr=pc (combinational from pc register).
  - On issue: pc<=pc+4 (wraps mod 2^XLEN); inflight<=1; inflightPc<=pc. Otherwise inflight<=0.
  - If inflight=1: push {inflightPc, imemData} into the FIFO this edge.
  - Overflow is impossible by construction; the bench asserts count<=DEPTH.
- Output timing:
  - instrValid=(count!=0). instrOut/pcOut come from the FIFO head (registered storage, no bypass).
  - Latency from issue to instrValid = 2 cycles.
  - With instrReady held 1, steady throughput is 1 instr/cycle.
- Back-pressure: instrValid=1 & instrReady=0 holds instrOut/pcOut stable. Issue stops once count+inflight reaches DEPTH.
- Push and pop in the same cycle: count unchanged, pointers both advance.
- Redirect (jumpEn=1) has priority over everything else in that cycle:
  - FIFO cleared (count<=0) and inflight<=0. A response arriving this cycle is dropped; so is the one for any request issued this cycle.
  - imemReq=0 this cycle.
  - pc<={jumpTarget[XLEN-1:2],2'b00}.
  - instrValid=0 from the next cycle. A pop in the redirect cycle is still honoured by decode, and decode is flushed externally anyway.
  - First fetch of the target is issued the cycle after jumpEn; instrValid rises 2 cycles after that.
- Back-to-back jumpEn: the last target wins; nothing is fetched until the first cycle with jumpEn=0.
- Reset asserted mid-operation: immediate return to reset state; the next issue is the first clk edge after deassertion, at RESET_PC.

Decomposition:
- Shared package riscv_pkg:
  - XLEN
  - RESET_PC
  - typedef fetch_entry_t {pc, instr}
- Sub-module fetch_fifo:
  - Parameterised DEPTH/width, synchronous FIFO with clear input.
  - Ports: clk, resetN, push, pushData, pop, clear, head, count.
- fetch_unit holds the pc/inflight/issue logic only.

Test Plan:
- Reset release, instrReady=1 for 6 cycles -> imemAddr 0,4,8,... from cycle 0; instrValid first high at cycle 2 with pcOut=0. Then pcOut=4,8,... on consecutive cycles.
- instrReady=0 from cycle 3 for 5 cycles -> issue stops once count+inflight=2; instrOut/pcOut constant. On ready=1, the stream resumes with no gap or duplicate (pc sequence contiguous).
- jumpEn=1, jumpTarget=0x100 while FIFO holds 2 entries and a request is in flight -> instrValid=0 next cycle. imemAddr=0x100 the following cycle; next pcOut=0x100; no stale pc seen.
- jumpEn on consecutive cycles with targets 0x200 then 0x300 -> only 0x300 is fetched; 0x200 never appears on pcOut.
- jumpTarget=0x103 -> fetch at 0x100. pc=0xFFFF_FFFC fetched -> next fetch 0x0000_0000 (wrap).
- resetN pulsed low mid-stream, async relative to clk -> all outputs zero immediately. After release the fetch restarts at RESET_PC; no pre-reset data is emitted.
